// File: rtl/eth_spi_pkg.sv
// Shared constants for the Ethernet controller SPI master:
// register map, STATUS/CONTROL bit positions and FSM encoding.
package eth_spi_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_CLEAR   = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;

  localparam int CT_CS_N    = 0;
  localparam int CT_IRQ_EN  = 1;
  localparam int CT_DIV_LSB = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/eth_spi_sync2.sv
// Two-flop synchroniser for the asynchronous eth_so input.
// Ports: clk, reset_n, d_i (async), q_o (clk domain, resets to 0).
module eth_spi_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/eth_spi_master_tx.sv
// Avalon-MM SPI master (mode 0, MSB first), one byte per TXDATA write.
// Ports: clk, reset_n, Avalon slave (address/chipselect/write_n/
// writedata/readdata), irq, SPI pins eth_sck/eth_si/eth_so/eth_cs_n.
module eth_spi_master_tx
  import eth_spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        eth_sck,
  output logic        eth_si,
  input  logic        eth_so,
  output logic        eth_cs_n
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  clkdiv_q, clkdiv_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rxdata_q, rxdata_d;
  logic              cs_n_q, cs_n_d;
  logic              irq_en_q, irq_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              sck_q, sck_d;
  logic              si_q, si_d;
  logic [31:0]       rd_q, rd_d;
  logic              so_sync;
  logic              wr_en;
  logic              unused_wd;

  eth_spi_sync2 u_so_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (eth_so),
    .q_o     (so_sync)
  );

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_comb begin
    rd_d = '0;
    unique case (address)
      ADDR_DATA:    rd_d[DATA_W-1:0] = rxdata_q;
      ADDR_STATUS: begin
        rd_d[ST_BUSY]    = busy_q;
        rd_d[ST_DONE]    = done_q;
        rd_d[ST_OVERRUN] = ovr_q;
      end
      ADDR_CONTROL: begin
        rd_d[CT_CS_N]              = cs_n_q;
        rd_d[CT_IRQ_EN]            = irq_en_q;
        rd_d[CT_DIV_LSB +: DIV_W]  = clkdiv_q;
      end
      default:      rd_d = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    clkdiv_d = clkdiv_q;
    div_d    = div_q;
    half_d   = half_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxdata_d = rxdata_q;
    cs_n_d   = cs_n_q;
    irq_en_d = irq_en_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    sck_d    = sck_q;
    si_d     = si_q;

    if (wr_en && address == ADDR_CONTROL) begin
      cs_n_d   = writedata[CT_CS_N];
      irq_en_d = writedata[CT_IRQ_EN];
      clkdiv_d = writedata[CT_DIV_LSB +: DIV_W];
    end
    if (wr_en && address == ADDR_CLEAR) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (wr_en && address == ADDR_DATA && busy_q) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (wr_en && address == ADDR_DATA) begin
          tx_d     = writedata[DATA_W-1:0];
          si_d     = writedata[DATA_W-1];
          busy_d   = 1'b1;
          bitcnt_d = CNT_W'(DATA_W);
          div_d    = clkdiv_q;
          half_d   = clkdiv_q;
          state_d  = S_LOW;
        end
      end
      S_LOW: begin
        if (half_q == '0) begin
          sck_d   = 1'b1;
          half_d  = div_q;
          state_d = S_HIGH;
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (half_q == '0) begin
          // Sample on the last SCK-high cycle, just before the fall.
          rx_d  = {rx_q[DATA_W-2:0], so_sync};
          sck_d = 1'b0;
          if (bitcnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            si_d     = tx_q[DATA_W-2];
            tx_d     = {tx_q[DATA_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q - 1'b1;
            half_d   = div_q;
            state_d  = S_LOW;
          end
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      default: begin
        // Setting done here overrides a same-cycle DONE_CLEAR.
        rxdata_d = rx_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      clkdiv_q <= DIV_W'(DEFAULT_DIV);
      div_q    <= '0;
      half_q   <= '0;
      bitcnt_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rxdata_q <= '0;
      cs_n_q   <= 1'b1;
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sck_q    <= 1'b0;
      si_q     <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      clkdiv_q <= clkdiv_d;
      div_q    <= div_d;
      half_q   <= half_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      cs_n_q   <= cs_n_d;
      irq_en_q <= irq_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      sck_q    <= sck_d;
      si_q     <= si_d;
      rd_q     <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = done_q & irq_en_q;
  assign eth_sck  = sck_q;
  assign eth_si   = si_q;
  assign eth_cs_n = cs_n_q;

endmodule
